// File: rtl/serial_seq_detector.sv
// Serial bit-stream detector: flags every (overlapping) occurrence of PATTERN,
// first-received bit at PATTERN[SEQ_LEN-1], with one-cycle registered latency.
module serial_seq_detector #(
  parameter int unsigned        SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic rst,
  input  logic SIn,
  output logic detected
);

  localparam int unsigned     CW   = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0]   FULL = CW'(SEQ_LEN);

  logic [SEQ_LEN-1:0] r_hist;
  logic [SEQ_LEN-1:0] w_hist_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic               w_match;

  // Next history/fill state; fill count gates matches so cleared history never fires
  always_comb begin
    w_hist_next = {r_hist[SEQ_LEN-2:0], SIn};
    w_cnt_next  = r_cnt;
    if (r_cnt < FULL) begin
      w_cnt_next = r_cnt + CW'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
    w_match = (w_cnt_next == FULL) && (w_hist_next == PATTERN);
  end

  // State and registered detect flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist   <= '0;
      r_cnt    <= '0;
      detected <= 1'b0;
    end else begin
      r_hist   <= w_hist_next;
      r_cnt    <= w_cnt_next;
      detected <= w_match;
    end
  end

endmodule

// File: tb/tb_serial_seq_detector.sv
// Directed bench for serial_seq_detector: default 1101 pattern plus an
// all-zeros instance exercising the fill guard.
module tb_serial_seq_detector;

  logic clk;
  logic rst;
  logic sin;
  logic det;
  logic rst_z;
  logic sin_z;
  logic det_z;

  int total;
  int bad;

  serial_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1101)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .SIn      (sin),
    .detected (det)
  );

  serial_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b0000)) u_dut_z (
    .clk      (clk),
    .rst      (rst_z),
    .SIn      (sin_z),
    .detected (det_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resets the main instance; returns just after a falling edge with rst=1,
  // so the next rising edge samples the first stream bit.
  task automatic do_reset();
    rst = 1'b0;
    sin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    rst_z = 1'b0;
    sin   = 1'b1;
    sin_z = 1'b0;
    #1;
    total++;
    if (det !== 1'b0) begin
      $display("FAIL reset_det got=%b want=0", det);
      bad++;
    end
    total++;
    if (det_z !== 1'b0) begin
      $display("FAIL reset_det_z got=%b want=0", det_z);
      bad++;
    end
    // SIn ignored while held in reset, even with many edges
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (det !== 1'b0 || det_z !== 1'b0) begin
      $display("FAIL reset_hold got=%b%b want=00", det, det_z);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4:0] bits;
    logic [4:0] exp;
    bits = 5'b11010;
    exp  = 5'b00010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sin = bits[4-i];
      @(posedge clk);
      #1;
      total++;
      if (det !== exp[4-i]) begin
        $display("FAIL basic edge%0d got=%b want=%b", i + 1, det, exp[4-i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] bits;
    logic [7:0] exp;
    int         pulses;
    bits   = 8'b11011010;
    exp    = 8'b00010010;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sin = bits[7-i];
      @(posedge clk);
      #1;
      if (det === 1'b1) pulses++;
      total++;
      if (det !== exp[7-i]) begin
        $display("FAIL overlap edge%0d got=%b want=%b", i + 1, det, exp[7-i]);
        bad++;
      end
      @(negedge clk);
    end
    total++;
    if (pulses != 2) begin
      $display("FAIL overlap_count got=%0d want=2", pulses);
      bad++;
    end
  endtask

  task automatic test_nonmatch();
    logic [11:0] bits;
    bits = 12'b101111100101;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      sin = bits[11-i];
      @(posedge clk);
      #1;
      total++;
      if (det !== 1'b0) begin
        $display("FAIL nonmatch edge%0d got=%b want=0", i + 1, det);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [4:0] bits;
    logic [4:0] exp;
    pre  = 3'b110;
    bits = 5'b11010;
    exp  = 5'b00010;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sin = pre[2-i];
      @(posedge clk);
      #1;
      total++;
      if (det !== 1'b0) begin
        $display("FAIL rmid_pre edge%0d got=%b want=0", i + 1, det);
        bad++;
      end
      @(negedge clk);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (det !== 1'b0) begin
      $display("FAIL rmid_inrst got=%b want=0", det);
      bad++;
    end
    #1 rst = 1'b1;
    // Old 110 plus this 1 must not complete a match
    sin = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (det !== 1'b0) begin
      $display("FAIL rmid_first got=%b want=0", det);
      bad++;
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sin = bits[4-i];
      @(posedge clk);
      #1;
      total++;
      if (det !== exp[4-i]) begin
        $display("FAIL rmid_post edge%0d got=%b want=%b", i + 1, det, exp[4-i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] pre;
    realtime    t_edge;
    pre = 3'b110;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sin = pre[2-i];
      @(posedge clk);
      @(negedge clk);
    end
    sin = 1'b1;
    @(posedge clk);
    t_edge = $realtime;
    #1;
    total++;
    if (det !== 1'b1) begin
      $display("FAIL async_pulse got=%b want=1", det);
      bad++;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (det !== 1'b0 || ($realtime - t_edge) >= 10.0) begin
      $display("FAIL async_drop got=%b want=0 dt=%0t", det, $realtime - t_edge);
      bad++;
    end
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (det !== 1'b0) begin
      $display("FAIL async_after got=%b want=0", det);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_fill_guard();
    logic [6:0] exp;
    exp   = 7'b0001111;
    rst_z = 1'b0;
    sin_z = 1'b0;
    repeat (2) @(negedge clk);
    rst_z = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sin_z = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (det_z !== exp[6-i]) begin
        $display("FAIL fill edge%0d got=%b want=%b", i + 1, det_z, exp[6-i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_overlap();
    test_nonmatch();
    test_reset_mid();
    test_async_reset();
    test_fill_guard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
